// File: rtl/rom_rd_pkg.sv
// rtl/rom_rd_pkg.sv - shared constants, state encoding and word-count decode for rom64_word_reader
package rom_rd_pkg;

    localparam int ADDR_W    = 6;
    localparam int ROM_DEPTH = 64;

    // A word count of zero requests a full run of sixteen words.
    localparam logic [4:0] NWRD_ZERO_WORDS = 5'd16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_e;

    function automatic logic [4:0] decode_nwrd(input logic [3:0] nwrd);
        return (nwrd == 4'd0) ? NWRD_ZERO_WORDS : {1'b0, nwrd};
    endfunction

endpackage

// File: rtl/rom64_word_reader.sv
// rtl/rom64_word_reader.sv - walks a 64x1 LUT ROM bit by bit and hands out LSB-first words over valid/ready
module rom64_word_reader
    import rom_rd_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              STRT,
    input  logic [5:0]        SADR,
    input  logic [3:0]        NWRD,
    output logic              AD0,
    output logic              AD1,
    output logic              AD2,
    output logic              AD3,
    output logic              AD4,
    output logic              AD5,
    input  logic              ROMDO,
    output logic [WORD_W-1:0] DOUT,
    output logic              DVAL,
    input  logic              DRDY,
    output logic              BUSY,
    output logic              XERR
);

    localparam logic [5:0]        LAST_BIT = 6'(WORD_W - 1);
    localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(ROM_DEPTH - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [5:0]          bitcnt_q, bitcnt_d;
    logic [4:0]          wrdcnt_q, wrdcnt_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic                xerr_q, xerr_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            bitcnt_q <= '0;
            wrdcnt_q <= '0;
            shreg_q  <= '0;
            xerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            bitcnt_q <= bitcnt_d;
            wrdcnt_q <= wrdcnt_d;
            shreg_q  <= shreg_d;
            xerr_q   <= xerr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        bitcnt_d = bitcnt_q;
        wrdcnt_d = wrdcnt_q;
        shreg_d  = shreg_q;
        xerr_d   = xerr_q;
        case (state_q)
            IDLE: begin
                if (STRT) begin
                    state_d  = FETCH;
                    addr_d   = SADR;
                    wrdcnt_d = decode_nwrd(NWRD);
                    bitcnt_d = '0;
                    xerr_d   = 1'b0;
                end
            end
            FETCH: begin
                // ROM is combinational, so ROMDO already reflects addr_q this cycle.
                for (int i = 0; i < WORD_W; i++) begin
                    if (bitcnt_q == 6'(i)) begin
                        shreg_d[i] = ROMDO;
                    end
                end
                if ($isunknown(ROMDO)) begin
                    xerr_d = 1'b1;
                end
                addr_d = (addr_q == LAST_ADR) ? '0 : addr_q + 6'd1;
                if (bitcnt_q == LAST_BIT) begin
                    bitcnt_d = '0;
                    state_d  = HOLD;
                end else begin
                    bitcnt_d = bitcnt_q + 6'd1;
                end
            end
            HOLD: begin
                if (DRDY) begin
                    wrdcnt_d = wrdcnt_q - 5'd1;
                    state_d  = (wrdcnt_q == 5'd1) ? IDLE : FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign {AD5, AD4, AD3, AD2, AD1, AD0} = addr_q;
    assign DOUT = shreg_q;
    assign DVAL = (state_q == HOLD);
    assign BUSY = (state_q != IDLE);
    assign XERR = xerr_q;

endmodule

// File: doc/rom64_word_reader.md
# rom64_word_reader

Sequencer that sits directly upstream of a 64x1 distributed ROM cell. It drives the ROM's six address lines, samples the ROM's combinational single-bit output one bit per clock, and assembles consecutive bits into WORD_W-bit words. Words are delivered to a downstream consumer over a valid/ready handshake. Typical uses are bit-packed init tables and coefficient tables held in LUT ROM.

## Interface
- WORD_W, 8, bits per output word; legal range 1..64
- CLK  in  1  clock; all logic on the rising edge
- RST  in  1  reset; synchronous, active-high
- STRT  in  1  single-cycle start request; sampled only when BUSY=0
- SADR  in  6  start bit address, captured with STRT
- NWRD  in  4  word count, captured with STRT; 0 means 16 words
- AD0..AD5  out  1 each  ROM address lines, registered; AD0 is the LSB
- ROMDO  in  1  ROM data output (DO0 of the ROM cell)
- DOUT  out  WORD_W  assembled word, LSB-first
- DVAL  out  1  DOUT valid
- DRDY  in  1  consumer ready
- BUSY  out  1  high from the cycle after STRT is accepted until the final word is transferred
- XERR  out  1  sticky flag; set when ROMDO is sampled as non-0/1

## Operation
- Reset values:
  - AD=0, DOUT=0, DVAL=0, BUSY=0, XERR=0.
  - State is IDLE; internal bit and word counters are 0.
- States:
  - IDLE -> FETCH when STRT=1. Capture SADR into the address register and NWRD into the word counter. Clear XERR. Set BUSY.
  - FETCH, one cycle per bit, WORD_W cycles per word. Each cycle:
    - shift ROMDO into bit position bitcnt of the shift register;
    - increment the address modulo 64 (63 -> 0 wraps);
    - increment bitcnt.
    - On the last bit, go to HOLD.
  - HOLD: DVAL=1 and DOUT = the assembled word.
    - If DVAL & DRDY and words remain: decrement the word counter, go to FETCH.
    - If DVAL & DRDY on the last word: go to IDLE and clear BUSY.
    - Otherwise hold. DOUT and DVAL must stay stable.
- Address continuity: the address carries across words. Word n starts at SADR + n*WORD_W, modulo 64.
- STRT while BUSY=1 is ignored. Nothing is queued.
- X handling:
  - A sampled ROMDO of X or Z is stored unchanged in DOUT.
  - XERR is set and stays set until the next accepted STRT or RST.
- RST at any point: return to IDLE with reset values in the same edge. A partial word is discarded.
- The address register is not cleared on normal completion. AD holds the address that follows the last bit read.

## Timing
- The ROM is combinational. ROMDO is sampled in the same cycle the registered address is presented, so the ROM adds no extra cycle of latency.
- STRT accepted at edge 0:
  - the first bit is sampled at edge 1;
  - the WORD_W-th bit is sampled at edge WORD_W;
  - DVAL=1 from edge WORD_W onward.
- First-word latency is WORD_W cycles after the STRT edge.
- Per-word throughput with DRDY held high is WORD_W+1 cycles (WORD_W fetch cycles plus 1 HOLD cycle).
- Transfer handshake:
  - A transfer occurs on an edge where DVAL=1 and DRDY=1.
  - DVAL drops at that same edge unless a new word is already complete. It cannot be, because the FETCH and HOLD states do not overlap.
- DRDY is ignored while DVAL=0.
- After the final transfer, BUSY drops at the same edge as DVAL. A new STRT is accepted from the following edge.

## Structure
- Shared package rom_rd_pkg holds:
  - ADDR_W=6 and ROM_DEPTH=64;
  - the state enum {IDLE, FETCH, HOLD};
  - the NWRD zero-means-16 decode constant.
- Single module; no sub-module is warranted.
- The bench instantiates the ROM cell as the downstream load, with AD0..AD5 connected and DO0 wired to ROMDO.

## Test plan
- ROM initval 64'h0123456789ABCDEF, WORD_W=8, SADR=0, NWRD=2, DRDY=1 -> DOUT=8'hEF, then 8'hCD; DVAL first rises 8 cycles after STRT; AD=16 at end; BUSY low after the second transfer.
- Same ROM, SADR=60, NWRD=1 -> wrap: DOUT=8'hF0 (bits 60..63 = 0, bits 0..3 = F); AD=4 at end.
- SADR=8, NWRD=1, DRDY held low 5 cycles after DVAL rises -> DOUT=8'hCD stable and DVAL=1 for all 5 cycles; transfer on the cycle DRDY rises; IDLE next.
- NWRD=0, WORD_W=4, SADR=0 -> 16 words F,E,D,C,B,A,9,8,7,6,5,4,3,2,1,0; a STRT pulsed during word 5 is ignored (word sequence unchanged).
- Force ROMDO=1'bx during bit 3 of word 0 -> XERR=1 and DOUT[3]=x; XERR persists after completion; next STRT clears it.
- RST=1 during bit 5 of FETCH -> next cycle AD=0, DVAL=0, BUSY=0, XERR=0; a subsequent STRT with SADR=0 returns 8'hEF.
